// File: rtl/hv_pair_streamer.sv
// hv_pair_streamer: fetches hypervectors A and B from a sync-read element
// memory and streams them interleaved (A0,B0,A1,B1,...) to the similarity
// unit. It then waits for the unit's done pulse, captures the result and
// reports it with a one-cycle result_valid pulse.
module hv_pair_streamer #(
  parameter int HV_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     start,
  input  logic [LEN_WIDTH-1:0]     len,
  input  logic [ADDR_WIDTH-1:0]    a_base,
  input  logic [ADDR_WIDTH-1:0]    b_base,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [HV_DATA_WIDTH-1:0] mem_rdata,
  output logic                     sim_valid,
  output logic                     sim_first,
  output logic                     sim_last,
  output logic [HV_DATA_WIDTH-1:0] sim_data,
  input  logic                     sim_ready,
  input  logic                     sim_done,
  input  logic [HV_DATA_WIDTH-1:0] sim_result,
  output logic [HV_DATA_WIDTH-1:0] result,
  output logic                     result_valid
);

  // Word counters cover 2N, so they need one bit more than len.
  localparam int CW = LEN_WIDTH + 1;
  localparam int SW = ADDR_WIDTH + LEN_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t state;
  state_t state_next;

  // Job parameters latched when start is accepted
  logic [CW-1:0]         total;
  logic [ADDR_WIDTH-1:0] a_base_q;
  logic [ADDR_WIDTH-1:0] b_base_q;

  // Read issue / acceptance bookkeeping
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] accept_cnt;
  logic          inflight;
  logic          inflight_first;
  logic          inflight_last;

  // Two-entry FIFO; first/last flags travel alongside the data
  logic [HV_DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]               fifo_first;
  logic [1:0]               fifo_last;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               occ;

  logic [HV_DATA_WIDTH-1:0] result_q;

  // Internal handshakes
  logic          start_ok;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [2:0]    pending;
  logic          issue;
  logic          last_issue;
  logic          last_accept;
  logic [LEN_WIDTH-1:0]  half_idx;
  logic [ADDR_WIDTH-1:0] base_sel;
  logic [SW-1:0]         addr_sum;

  // Issue/accept decisions. The slot freed by this cycle's pop is counted so
  // that a continuously ready sink sees one word per cycle, while the FIFO
  // still always has room for every read in flight.
  always_comb begin
    start_ok    = (state == S_IDLE) && start;
    fifo_empty  = (occ == 2'd0);
    push        = inflight;
    pop         = !fifo_empty && sim_ready;
    pending     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue       = (state == S_STREAM) && (issue_cnt != total) && (pending < 3'd2);
    last_issue  = issue && (issue_cnt == total - CW'(1));
    last_accept = pop && (accept_cnt == total - CW'(1));
    half_idx    = issue_cnt[CW-1:1];
    base_sel    = issue_cnt[0] ? b_base_q : a_base_q;
    addr_sum    = {{LEN_WIDTH{1'b0}}, base_sel} + {{ADDR_WIDTH{1'b0}}, half_idx};
  end

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? S_RESULT : S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_issue) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_accept) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sim_done) begin
          state_next = S_RESULT;
        end
      end
      S_RESULT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic; memory address and stream outputs read zero when unqualified
  always_comb begin
    busy         = (state != S_IDLE);
    result_valid = (state == S_RESULT);
    result       = result_q;
    mem_rd_en    = issue;
    mem_addr     = issue ? addr_sum[ADDR_WIDTH-1:0] : '0;
    sim_valid    = !fifo_empty;
    sim_data     = fifo_empty ? '0 : fifo_data[rd_ptr];
    sim_first    = !fifo_empty && fifo_first[rd_ptr];
    sim_last     = !fifo_empty && fifo_last[rd_ptr];
  end

  // Latch job parameters when a start is accepted; total word count is 2N
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      total    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
    end else if (start_ok) begin
      total    <= {len, 1'b0};
      a_base_q <= a_base;
      b_base_q <= b_base;
    end
  end

  // Count reads issued in the current job
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      issue_cnt <= '0;
    end else if (start_ok) begin
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + CW'(1);
    end
  end

  // Track the single outstanding read and the flags of the word it returns
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      inflight       <= 1'b0;
      inflight_first <= 1'b0;
      inflight_last  <= 1'b0;
    end else begin
      inflight       <= issue;
      inflight_first <= issue && (issue_cnt == '0);
      inflight_last  <= last_issue;
    end
  end

  // FIFO storage: returning read data is always written at the tail
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_first <= '0;
      fifo_last  <= '0;
    end else if (push) begin
      fifo_data[wr_ptr]  <= mem_rdata;
      fifo_first[wr_ptr] <= inflight_first;
      fifo_last[wr_ptr]  <= inflight_last;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave occupancy unchanged
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  // Count words accepted by the similarity unit in the current job
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      accept_cnt <= '0;
    end else if (start_ok) begin
      accept_cnt <= '0;
    end else if (pop) begin
      accept_cnt <= accept_cnt + CW'(1);
    end
  end

  // Capture the similarity result; an empty job reports zero
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      result_q <= '0;
    end else if (start_ok && (len == '0)) begin
      result_q <= '0;
    end else if ((state == S_WAIT_DONE) && sim_done) begin
      result_q <= sim_result;
    end
  end

endmodule
